// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed scan driver for a bi-colour LED board.
// Snapshots the red/green frame at each frame start. Column data is shifted
// MSB-column first into two serial column registers, then latched. The
// selected row is displayed for DWELL cycles.
// Optional feature macro: LED_SCAN_DIM_EN. It adds the bright[3:0] input,
// which shortens the oe_n low window inside each row's display time.
module led_matrix_scanner #(
  parameter int unsigned ROWS    = 16,
  parameter int unsigned COLS    = 16,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 1024
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       enable,
`ifdef LED_SCAN_DIM_EN
  input  logic [3:0]                 bright,
`endif
  input  logic [ROWS-1:0][COLS-1:0]  red,
  input  logic [ROWS-1:0][COLS-1:0]  green,
  output logic [ROWS-1:0]            row_n,
  output logic                       sclk,
  output logic                       sdata_r,
  output logic                       sdata_g,
  output logic                       latch,
  output logic                       oe_n,
  output logic                       frame_start
);

  localparam int unsigned SHIFT_LEN = 2 * CLK_DIV * COLS;
  localparam int unsigned CNT_TOP   = (SHIFT_LEN > DWELL) ? SHIFT_LEN : DWELL;
  localparam int unsigned CW        = $clog2(CNT_TOP + 1);
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CLW       = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                     state, state_d;
  logic [CW-1:0]              cnt, cnt_d;
  logic [RW-1:0]              row, row_d;
  logic [ROWS-1:0][COLS-1:0]  snap_r, snap_g;
  logic                       snap_en;

  logic [CW-1:0]              bit_idx;
  logic [CLW-1:0]             col;
  logic                       phase_hi;
  logic [ROWS-1:0]            row_sel;
  logic [ROWS-1:0]            row_one;

  logic [ROWS-1:0]            row_n_d;
  logic                       sclk_d, sdata_r_d, sdata_g_d, latch_d, oe_n_d, frame_start_d;

`ifdef LED_SCAN_DIM_EN
  logic [3:0]                 bright_q;
  logic [3:0]                 bright_eff;
  logic [31:0]                on_len;
`endif

  // Next-state, phase counter and row pointer.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    row_d   = row;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt == CW'(SHIFT_LEN - 1)) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        cnt_d   = '0;
      end
      S_DISPLAY: begin
        if (cnt == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_LOAD;
            row_d   = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // State, counter and row registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      row   <= row_d;
    end
  end

  assign snap_en = (state_d == S_LOAD) && (row_d == '0);

  // Frame snapshot, taken on the edge that enters LOAD for row 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_r <= '0;
      snap_g <= '0;
    end else if (snap_en) begin
      snap_r <= red;
      snap_g <= green;
    end
  end

`ifdef LED_SCAN_DIM_EN
  // Brightness captured during LATCH and held for the following display.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bright_q <= '0;
    end else if (state == S_LATCH) begin
      bright_q <= bright;
    end
  end
`endif

  // Output decode from the next state so every output is a plain register
  // that lines up with the state it describes.
  always_comb begin
    bit_idx   = cnt_d / CW'(2 * CLK_DIV);
    col       = CLW'(COLS - 1) - CLW'(bit_idx);
    phase_hi  = (cnt_d % CW'(2 * CLK_DIV)) >= CW'(CLK_DIV);
    row_one   = '0;
    row_one[0] = 1'b1;
    row_sel   = ~(row_one << row_d);
`ifdef LED_SCAN_DIM_EN
    bright_eff = (state == S_LATCH) ? bright : bright_q;
    on_len     = (32'(bright_eff) + 32'd1) * 32'(DWELL / 16);
`endif
    row_n_d       = '1;
    sclk_d        = 1'b0;
    sdata_r_d     = 1'b0;
    sdata_g_d     = 1'b0;
    latch_d       = 1'b0;
    oe_n_d        = 1'b1;
    frame_start_d = 1'b0;
    case (state_d)
      S_LOAD: begin
        frame_start_d = snap_en;
      end
      S_SHIFT: begin
        sclk_d    = phase_hi;
        sdata_r_d = snap_r[row_d][col];
        sdata_g_d = snap_g[row_d][col];
      end
      S_LATCH: begin
        latch_d = 1'b1;
        row_n_d = row_sel;
      end
      S_DISPLAY: begin
        row_n_d = row_sel;
`ifdef LED_SCAN_DIM_EN
        oe_n_d  = !(32'(cnt_d) < on_len);
`else
        oe_n_d  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Registered board outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_n       <= '1;
      sclk        <= 1'b0;
      sdata_r     <= 1'b0;
      sdata_g     <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      row_n       <= row_n_d;
      sclk        <= sclk_d;
      sdata_r     <= sdata_r_d;
      sdata_g     <= sdata_g_d;
      latch       <= latch_d;
      oe_n        <= oe_n_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (CLK_DIV=1, DWELL=16, 16x16).
// The reference is a row-timeline model: position within the row period
// plus row number, from which every output is derived arithmetically.
module tb_led_matrix_scanner;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int CLK_DIV   = 1;
  localparam int DWELL     = 16;
  localparam int SHIFT_LEN = 2 * CLK_DIV * COLS;
  localparam int ROW_PER   = 2 + SHIFT_LEN + DWELL;

  logic                      CLK = 1'b0;
  logic                      RST_N = 1'b0;
  logic                      enable = 1'b0;
  logic [ROWS-1:0][COLS-1:0] red, green;
  logic [ROWS-1:0]           row_n;
  logic                      sclk, sdata_r, sdata_g, latch, oe_n, frame_start;
`ifdef LED_SCAN_DIM_EN
  logic [3:0]                bright = 4'd15;
  logic [3:0]                bright_fix = 4'd15;
  logic                      bright_rand = 1'b0;
`endif

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DWELL(DWELL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
`ifdef LED_SCAN_DIM_EN
    .bright(bright),
`endif
    .red(red), .green(green), .row_n(row_n), .sclk(sclk),
    .sdata_r(sdata_r), .sdata_g(sdata_g), .latch(latch), .oe_n(oe_n),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_fail = 0;
  int cyc_n = 0;

  logic [31:0] out_vec;
  assign out_vec = 32'({row_n, sclk, sdata_r, sdata_g, latch, oe_n, frame_start});
  localparam logic [31:0] RESET_VEC = 32'h003F_FFC2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  bit                        m_active = 1'b0;
  int                        m_p = 0;
  int                        m_row = 0;
  int                        m_bright = 15;
  logic [ROWS-1:0][COLS-1:0] m_snap_r = '0;
  logic [ROWS-1:0][COLS-1:0] m_snap_g = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_active = 1'b0;
      m_p      = 0;
      m_row    = 0;
      m_snap_r = '0;
      m_snap_g = '0;
    end else if (!m_active) begin
      if (enable) begin
        m_active = 1'b1;
        m_p      = 0;
        m_row    = 0;
        m_snap_r = red;
        m_snap_g = green;
      end
    end else if (m_p == ROW_PER - 1) begin
      if (enable) begin
        m_row = (m_row + 1) % ROWS;
        m_p   = 0;
        if (m_row == 0) begin
          m_snap_r = red;
          m_snap_g = green;
        end
      end else begin
        m_active = 1'b0;
        m_row    = 0;
      end
    end else begin
`ifdef LED_SCAN_DIM_EN
      if (m_p == SHIFT_LEN + 1) m_bright = int'(bright);
`endif
      m_p++;
    end
  end

  function automatic logic [31:0] model_out();
    logic [ROWS-1:0] rn, one;
    logic sc, sr, sg, la, oe, fs;
    int s, c;
    one = '0;
    one[0] = 1'b1;
    rn = '1; sc = 0; sr = 0; sg = 0; la = 0; oe = 1; fs = 0;
    if (m_active) begin
      if (m_p == 0) begin
        fs = (m_row == 0);
      end else if (m_p <= SHIFT_LEN) begin
        s  = m_p - 1;
        c  = COLS - 1 - s / (2 * CLK_DIV);
        sc = (s % (2 * CLK_DIV)) >= CLK_DIV;
        sr = m_snap_r[m_row][c];
        sg = m_snap_g[m_row][c];
      end else if (m_p == SHIFT_LEN + 1) begin
        la = 1'b1;
        rn = ~(one << m_row);
      end else begin
        rn = ~(one << m_row);
`ifdef LED_SCAN_DIM_EN
        oe = !((m_p - SHIFT_LEN - 2) < (m_bright + 1) * (DWELL / 16));
`else
        oe = 1'b0;
`endif
      end
    end
    return 32'({rn, sc, sr, sg, la, oe, fs});
  endfunction

  // Cycle-by-cycle compare against the model.
  always @(negedge CLK) check("outputs", out_vec, model_out());

  // ---------------- board-side monitor ----------------
  logic [COLS-1:0] wr = '0, wg = '0;
  logic            prev_sclk = 1'b0;
  logic [COLS-1:0] rword [ROWS];
  logic [COLS-1:0] gword [ROWS];
  int              fs_time [16];
  int              fs_count = 0;

  always @(negedge CLK) begin
    cyc_n++;
    if (sclk && !prev_sclk) begin
      wr = {wr[COLS-2:0], sdata_r};
      wg = {wg[COLS-2:0], sdata_g};
    end
    prev_sclk = sclk;
    if (latch) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!row_n[r]) begin
          rword[r] = wr;
          gword[r] = wg;
        end
      end
    end
    if (frame_start) begin
      if (fs_count < 16) fs_time[fs_count] = cyc_n;
      fs_count++;
    end
  end

  // ---------------- frame data scrambler ----------------
  logic [COLS-1:0] row7_val = 16'h5A5A;

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      red[r]   = COLS'($urandom);
      green[r] = COLS'($urandom);
    end
    red[0]   = 16'h8001;
    green[0] = 16'h0000;
    red[7]   = row7_val;
    green[7] = ~row7_val;
    forever begin
      @(posedge CLK);
      #3;
      if ($urandom_range(3) == 0) begin
        int r;
        r = $urandom_range(1, 14);
        if (r >= 7) r++;
        red[r]   = COLS'($urandom);
        green[r] = COLS'($urandom);
      end
      red[7]   = row7_val;
      green[7] = ~row7_val;
`ifdef LED_SCAN_DIM_EN
      bright = bright_rand ? 4'($urandom) : bright_fix;
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fs(input int bound, output int cyc);
    bit found;
    found = 0;
    cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      cyc++;
      if (frame_start) begin
        found = 1;
        break;
      end
    end
    check("frame_start_seen", 32'(found), 32'd1);
  endtask

  // row < 0 waits for a latch of any row.
  task automatic wait_latch(input int row, input int bound);
    bit found;
    logic [ROWS-1:0] one;
    one = '0;
    one[0] = 1'b1;
    found = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (latch && (row < 0 || row_n == ~(one << row))) begin
        found = 1;
        break;
      end
    end
    check("latch_seen", 32'(found), 32'd1);
  endtask

  task automatic count_oe_low(input int n, input logic [ROWS-1:0] rsel, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (!oe_n && row_n == rsel) cnt++;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, lows;
    bit found;

    repeat (3) tick();
    check("reset_outputs", out_vec, RESET_VEC);
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
    check("idle_outputs", out_vec, RESET_VEC);

    // Row 0 carries 8001 red / 0000 green.
    enable = 1'b1;
    wait_fs(4, cyc);
    check("first_fs_latency", 32'(cyc), 32'd2);
    wait_latch(0, 60);
    count_oe_low(20, 16'hFFFE, lows);
    check("row0_oe_low_cycles", 32'(lows), 32'd16);
    check("row0_red_word", 32'(rword[0]), 32'h8001);
    check("row0_green_word", 32'(gword[0]), 32'h0000);

    // Frame period and snapshot isolation on row 7.
    row7_val = 16'h0000;
    wait_fs(1000, cyc);
    tick();
    check("frame_period_1", 32'(fs_time[1] - fs_time[0]), 32'd800);
    wait_latch(5, 400);
    tick();
    row7_val = 16'hFFFF;
    wait_latch(7, 200);
    tick();
    check("row7_old_red", 32'(rword[7]), 32'h0000);
    check("row7_old_green", 32'(gword[7]), 32'hFFFF);
    wait_fs(1000, cyc);
    tick();
    check("frame_period_2", 32'(fs_time[2] - fs_time[1]), 32'd800);
    wait_latch(7, 500);
    tick();
    check("row7_new_red", 32'(rword[7]), 32'hFFFF);
    check("row7_new_green", 32'(gword[7]), 32'h0000);

    // Enable dropped during row 3 shift.
    wait_latch(2, 900);
    repeat (DWELL + 7) tick();
    enable = 1'b0;
    count_oe_low(80, 16'hFFF7, lows);
    check("row3_completes_display", 32'(lows), 32'd16);
    check("idle_after_drop", 32'({row_n, oe_n}), 32'h1FFFF);
    tick();
    enable = 1'b1;
    wait_fs(4, cyc);
    check("reenable_fs_latency", 32'(cyc), 32'd2);

    // Asynchronous reset in the middle of SHIFT.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (sclk) begin
        found = 1;
        break;
      end
    end
    check("shift_seen", 32'(found), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs", out_vec, RESET_VEC);
    tick();
    tick();
    RST_N = 1'b1;
    wait_fs(4, cyc);
    check("post_reset_fs_latency", 32'(cyc), 32'd2);

`ifdef LED_SCAN_DIM_EN
    bright_fix = 4'd3;
    repeat (3) tick();
    wait_latch(-1, 100);
    count_oe_low(20, row_n, lows);
    check("dim_bright3", 32'(lows), 32'd4);
    bright_fix = 4'd15;
    repeat (3) tick();
    wait_latch(-1, 100);
    count_oe_low(20, row_n, lows);
    check("dim_bright15", 32'(lows), 32'd16);
    bright_rand = 1'b1;
`endif

    // Random enable activity checked by the model.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(200, 600)) tick();
      enable = ($urandom_range(3) != 0);
    end
    enable = 1'b1;
    repeat (900) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
